// File: rtl/rvfi_step_sequencer_pkg.sv
// Shared RVFI types and limits for the retirement-to-ISS step sequencer.
package rvfi_step_sequencer_pkg;

    localparam int unsigned NRET_MIN  = 1;
    localparam int unsigned NRET_MAX  = 4;
    localparam int unsigned DEPTH_MIN = 4;
    localparam int unsigned DEPTH_MAX = 32;
    localparam int unsigned ORDER_W   = 64;
    localparam int unsigned XLEN      = 32;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [XLEN-1:0]    insn;
        logic [XLEN-1:0]    pc_rdata;
        logic [XLEN-1:0]    pc_wdata;
        logic [4:0]         rd_addr;
        logic [XLEN-1:0]    rd_wdata;
        logic               trap;
    } st_rvfi;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IRQ  = 2'd1,
        ST_STEP = 2'd2,
        ST_OUT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rvfi_step_sequencer_retire_queue.sv
// Multi-push, single-pop circular buffer of retirement records; a cycle whose
// valid lanes do not fit is dropped whole and flagged.
module rvfi_retire_queue
    import rvfi_step_sequencer_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NRET-1:0]          push_valid,
    input  st_rvfi [NRET-1:0]        push_data,
    input  logic                     pop,
    output st_rvfi                   head_c,
    output logic                     empty_c,
    output logic                     accept_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    st_rvfi         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  slot [NRET];
    logic [CW-1:0]  n_push;
    logic [CW-1:0]  free;
    logic           pop_ok;

    assign empty_c  = (count == '0);
    assign pop_ok   = pop && !empty_c;
    assign head_c   = mem[rd_ptr];
    assign free     = CW'(DEPTH) - count + CW'(pop_ok);
    assign accept_c = (n_push <= free);

    // Compact valid lanes: lane i lands after all lower valid lanes.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NRET; i++) begin
            slot[i] = wr_ptr + n_push[AW-1:0];
            n_push  = n_push + CW'(push_valid[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept_c) begin
                for (int i = 0; i < NRET; i++) begin
                    if (push_valid[i]) begin
                        mem[slot[i]] <= push_data[i];
                    end
                end
                wr_ptr <= wr_ptr + n_push[AW-1:0];
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (accept_c ? n_push : '0) - CW'(pop_ok);
            if (!accept_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvfi_step_sequencer.sv
// Feeds retired core records to an ISS one step at a time, interleaving
// interrupt-vector updates and returning ISS results to the scoreboard.
module rvfi_step_sequencer
    import rvfi_step_sequencer_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IRQ_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NRET-1:0]          in_valid,
    input  st_rvfi [NRET-1:0]        in_rvfi,
    input  logic [IRQ_W-1:0]         irq_i,
    output logic                     irq_req,
    output logic [IRQ_W-1:0]         irq_data,
    input  logic                     irq_ack,
    output logic                     step_req,
    output st_rvfi                   step_in,
    input  logic                     step_ack,
    input  st_rvfi                   step_out,
    output logic                     out_valid,
    output st_rvfi                   out_rvfi,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     order_err_o
);

    if (NRET < NRET_MIN || NRET > NRET_MAX || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_err
        $error("rvfi_step_sequencer: unsupported NRET/DEPTH");
    end

    seq_state_e          state, state_nxt;
    st_rvfi              q_head_c;
    logic                q_empty_c, q_accept_c;
    logic                pop_c, load_irq_c, load_step_c, load_out_c, irq_clr_c;
    logic [IRQ_W-1:0]    irq_q, irq_latch;
    logic                irq_pending, irq_chg_c;
    logic [ORDER_W-1:0]  last_order, ord_prev_c;
    logic                order_armed, ord_armed_c, ord_bad_c;

    rvfi_retire_queue #(.NRET(NRET), .DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (in_valid),
        .push_data  (in_rvfi),
        .pop        (pop_c),
        .head_c     (q_head_c),
        .empty_c    (q_empty_c),
        .accept_c   (q_accept_c),
        .count      (count_o),
        .overflow   (overflow_o)
    );

    // Sequential order check across the lanes of one cycle.
    always_comb begin
        ord_bad_c   = 1'b0;
        ord_prev_c  = last_order;
        ord_armed_c = order_armed;
        for (int i = 0; i < NRET; i++) begin
            if (in_valid[i]) begin
                if (ord_armed_c && (in_rvfi[i].order != ord_prev_c + ORDER_W'(1))) begin
                    ord_bad_c = 1'b1;
                end
                ord_prev_c  = in_rvfi[i].order;
                ord_armed_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_order  <= '0;
            order_armed <= 1'b0;
            order_err_o <= 1'b0;
        end else if (q_accept_c && (|in_valid)) begin
            last_order  <= ord_prev_c;
            order_armed <= ord_armed_c;
            if (ord_bad_c) begin
                order_err_o <= 1'b1;
            end
        end
    end

    assign irq_chg_c = (irq_i != irq_q);

    // A value change still undelivered after the ack keeps the request pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q       <= '0;
            irq_latch   <= '0;
            irq_pending <= 1'b0;
        end else begin
            irq_q <= irq_i;
            if (irq_chg_c) begin
                irq_pending <= 1'b1;
                irq_latch   <= irq_i;
            end else if (irq_clr_c) begin
                irq_pending <= (irq_latch != irq_data);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pop_c       = 1'b0;
        load_irq_c  = 1'b0;
        load_step_c = 1'b0;
        load_out_c  = 1'b0;
        irq_clr_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (irq_pending) begin
                    state_nxt  = ST_IRQ;
                    load_irq_c = 1'b1;
                end else if (!q_empty_c) begin
                    state_nxt   = ST_STEP;
                    load_step_c = 1'b1;
                end
            end
            ST_IRQ: begin
                if (irq_ack) begin
                    irq_clr_c = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (step_ack) begin
                    pop_c      = 1'b1;
                    load_out_c = 1'b1;
                    state_nxt  = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs follow the next state so they are flops, not decodes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_req   <= 1'b0;
            step_req  <= 1'b0;
            out_valid <= 1'b0;
            irq_data  <= '0;
            step_in   <= '0;
            out_rvfi  <= '0;
        end else begin
            irq_req   <= (state_nxt == ST_IRQ);
            step_req  <= (state_nxt == ST_STEP);
            out_valid <= (state_nxt == ST_OUT);
            if (load_irq_c) begin
                irq_data <= irq_latch;
            end
            if (load_step_c) begin
                step_in <= q_head_c;
            end
            if (load_out_c) begin
                out_rvfi <= step_out;
            end
        end
    end

endmodule

// File: doc/rvfi_step_sequencer.md
RVFI_STEP_SEQUENCER -- requirements
Module: rvfi_step_sequencer

Interface
REQ-001 Parameters SHALL be: NRET, default 2, retirement lanes (1..4); DEPTH, default 8, queue entries (power of 2, 4..32); IRQ_W, default 32, interrupt vector width.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  NRET  per-lane retirement valid, no backpressure.
REQ-005 in_rvfi  in  NRET x st_rvfi  per-lane retirement record.
REQ-006 irq_i  in  IRQ_W  interrupt drive vector.
REQ-007 irq_req / irq_data  out  1 / IRQ_W  ISS interrupt-update request and value.
REQ-008 irq_ack  in  1  ISS accepted interrupt update.
REQ-009 step_req / step_in  out  1 / st_rvfi  ISS step request and core record.
REQ-010 step_ack / step_out  in  1 / st_rvfi  ISS step done and ISS record.
REQ-011 out_valid / out_rvfi  out  1 / st_rvfi  ISS result to scoreboard.
REQ-012 out_ready  in  1  scoreboard accepts result.
REQ-013 count_o  out  clog2(DEPTH)+1  queue occupancy.
REQ-014 overflow_o / order_err_o  out  1 / 1  sticky error flags.

Function
REQ-015 Each cycle, valid lanes SHALL be compacted and pushed in ascending lane index; invalid lanes ignored.
REQ-016 If valid-lane count exceeds free entries (after same-cycle pop), the whole cycle's records SHALL be dropped and overflow_o set.
REQ-017 Push and pop in the same cycle SHALL both occur; count_o = count + pushes - pop.
REQ-018 Pointers SHALL wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-019 Each accepted record's order SHALL equal previous accepted order+1 (first after reset exempt), else order_err_o set; record still queued.
REQ-020 irq_i SHALL be registered each cycle; any difference from the registered value SHALL set irq_pending and latch irq_i into irq_data (later changes overwrite before delivery).
REQ-021 FSM states: IDLE, IRQ, STEP, OUT.
REQ-022 IDLE: irq_pending -> IRQ; else non-empty -> STEP; else stay. IRQ has priority over STEP.
REQ-023 IRQ: irq_req=1, irq_data stable; on irq_ack clear irq_pending (unless a new change arrives same cycle) -> IDLE.
REQ-024 STEP: step_req=1, step_in=queue head, stable until step_ack; on step_ack pop head, capture step_out into out register -> OUT.
REQ-025 OUT: out_valid=1, out_rvfi stable; on out_ready -> IDLE; minimum latency push-to-out_valid 3 cycles with single-cycle ack.
REQ-026 step_req and irq_req SHALL never be high together; out_valid SHALL never be high in STEP or IRQ.
REQ-027 Acks arriving outside their state SHALL be ignored.

Reset
REQ-028 On reset_n low: FSM=IDLE, pointers/count=0, irq_pending=0, irq register=0, out_valid/step_req/irq_req=0, records cleared, sticky flags cleared, order check re-armed.
REQ-029 Reset mid-handshake SHALL abandon the transaction; no output asserts in the first cycle after release.

Structure
REQ-030 st_rvfi, the FSM state enum and NRET/DEPTH limits SHALL live in the shared rvfi package.
REQ-031 The queue SHALL be one sub-module, rvfi_retire_queue (multi-push, single-pop circular buffer with count and overflow).

Verification
REQ-032 NRET=2, both lanes valid orders 1,2, acks immediate, out_ready=1 -> out_rvfi orders 1 then 2, out_valid first 3 cycles after push.
REQ-033 DEPTH=4 full, step_ack held low, push 1 lane -> dropped, overflow_o=1, count_o stays 4.
REQ-034 irq_i 0->0x800 while queue holds order 5 -> irq_req with 0x800 completes before step_req for order 5.
REQ-035 Lane orders 7 then 9 -> order_err_o=1, both records still stepped.
REQ-036 out_ready low 10 cycles -> out_valid and out_rvfi stable, no further step_req.
REQ-037 reset_n low during STEP with 3 queued -> count_o=0, step_req=0; post-reset push order 100 accepted without order_err_o.
